// File: rtl/alu_serial_sequencer_if.sv
// Handshake and operand/result bundle for the bit-serial ALU sequencer.
interface alu_serial_sequencer_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carryout;
  logic             overflow;
  logic             zero;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, carryout, overflow, zero
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, carryout, overflow, zero
  );
endinterface

// File: rtl/alu_serial_sequencer.sv
// Bit-serial ALU: one slice stepped LSB-first, one bit per clock, result behind valid/ready.
// Optional macro ALU_SEQ_ABORT_EN adds an abort input that cancels RUN/FIX.
module alu_serial_sequencer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic clk,
  input  logic reset,
`ifdef ALU_SEQ_ABORT_EN
  input  logic abort,
`endif
  alu_serial_sequencer_if.slave bus
);

  localparam int unsigned CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_XOR = 3'd2;
  localparam logic [2:0] OP_SLT = 3'd3;
  localparam logic [2:0] OP_AND = 3'd4;
  localparam logic [2:0] OP_NAND = 3'd5;
  localparam logic [2:0] OP_NOR = 3'd6;

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_e;

  typedef struct packed {
    logic [2:0] sel;
    logic       invta;
    logic       invtb;
    logic       cin;
  } slice_ctrl_t;

  state_e           state_q;
  logic [2:0]       sel_q;
  logic             invta_q;
  logic             invtb_q;
  logic             is_slt_q;
  logic             is_arith_q;
  logic [WIDTH-1:0] a_sh_q;
  logic [WIDTH-1:0] b_sh_q;
  logic [WIDTH-2:0] res_sh_q;
  logic             carry_q;
  logic             cin_msb_q;
  logic             sign_q;
  logic [CNT_W-1:0] cnt_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] result_q;
  logic             carryout_q;
  logic             overflow_q;
  logic             zero_q;

  slice_ctrl_t      ctrl_dec;
  logic             sa;
  logic             sb;
  logic             slice_res;
  logic             slice_cout;
  logic [WIDTH-2:0] res_sh_d;
  logic [WIDTH-1:0] final_res;
  logic             last_bit;
  logic             slt_bit;

  // Opcode to slice control decode (AND/OR realised as NOR/NAND of inverted inputs).
  always_comb begin
    ctrl_dec = '0;
    case (bus.op)
      OP_ADD:  ctrl_dec = '{sel: 3'd0, invta: 1'b0, invtb: 1'b0, cin: 1'b0};
      OP_SUB:  ctrl_dec = '{sel: 3'd0, invta: 1'b0, invtb: 1'b1, cin: 1'b1};
      OP_XOR:  ctrl_dec = '{sel: 3'd2, invta: 1'b0, invtb: 1'b0, cin: 1'b0};
      OP_SLT:  ctrl_dec = '{sel: 3'd0, invta: 1'b0, invtb: 1'b1, cin: 1'b1};
      OP_AND:  ctrl_dec = '{sel: 3'd6, invta: 1'b1, invtb: 1'b1, cin: 1'b0};
      OP_NAND: ctrl_dec = '{sel: 3'd5, invta: 1'b0, invtb: 1'b0, cin: 1'b0};
      OP_NOR:  ctrl_dec = '{sel: 3'd6, invta: 1'b0, invtb: 1'b0, cin: 1'b0};
      default: ctrl_dec = '{sel: 3'd5, invta: 1'b1, invtb: 1'b1, cin: 1'b0};
    endcase
  end

  // The single ALU slice.
  always_comb begin
    sa         = a_sh_q[0] ^ invta_q;
    sb         = b_sh_q[0] ^ invtb_q;
    slice_cout = (sa & sb) | (carry_q & (sa ^ sb));
    case (sel_q)
      3'd0:    slice_res = sa ^ sb ^ carry_q;
      3'd2:    slice_res = a_sh_q[0] ^ b_sh_q[0];
      3'd5:    slice_res = ~(sa & sb);
      3'd6:    slice_res = ~(sa | sb);
      default: slice_res = 1'b0;
    endcase
  end

  assign res_sh_d  = (WIDTH-1)'({slice_res, res_sh_q} >> 1);
  assign final_res = {slice_res, res_sh_q};
  assign last_bit  = (cnt_q == CNT_W'(WIDTH - 1));
  assign slt_bit   = sign_q ^ cin_msb_q ^ carry_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      sel_q       <= '0;
      invta_q     <= 1'b0;
      invtb_q     <= 1'b0;
      is_slt_q    <= 1'b0;
      is_arith_q  <= 1'b0;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      res_sh_q    <= '0;
      carry_q     <= 1'b0;
      cin_msb_q   <= 1'b0;
      sign_q      <= 1'b0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      carryout_q  <= 1'b0;
      overflow_q  <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            sel_q      <= ctrl_dec.sel;
            invta_q    <= ctrl_dec.invta;
            invtb_q    <= ctrl_dec.invtb;
            carry_q    <= ctrl_dec.cin;
            is_slt_q   <= (bus.op == OP_SLT);
            is_arith_q <= (bus.op == OP_ADD) || (bus.op == OP_SUB);
            a_sh_q     <= bus.a;
            b_sh_q     <= bus.b;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= RUN;
          end
        end
        RUN: begin
`ifdef ALU_SEQ_ABORT_EN
          if (abort) begin
            in_ready_q <= 1'b1;
            state_q    <= IDLE;
          end else
`endif
          begin
            a_sh_q   <= a_sh_q >> 1;
            b_sh_q   <= b_sh_q >> 1;
            res_sh_q <= res_sh_d;
            carry_q  <= slice_cout;
            cnt_q    <= cnt_q + CNT_W'(1);
            if (last_bit) begin
              cin_msb_q <= carry_q;
              sign_q    <= slice_res;
              if (is_slt_q) begin
                state_q <= FIX;
              end else begin
                result_q    <= final_res;
                zero_q      <= (final_res == '0);
                carryout_q  <= is_arith_q & slice_cout;
                overflow_q  <= is_arith_q & (carry_q ^ slice_cout);
                out_valid_q <= 1'b1;
                state_q     <= DONE;
              end
            end
          end
        end
        FIX: begin
`ifdef ALU_SEQ_ABORT_EN
          if (abort) begin
            in_ready_q <= 1'b1;
            state_q    <= IDLE;
          end else
`endif
          begin
            result_q    <= {{(WIDTH-1){1'b0}}, slt_bit};
            zero_q      <= ~slt_bit;
            carryout_q  <= 1'b0;
            overflow_q  <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.carryout  = carryout_q;
  assign bus.overflow  = overflow_q;
  assign bus.zero      = zero_q;

endmodule
